viterbi_frame_decoder: RTL and testbench
========================================

# viterbi_frame_decoder

Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7/5 octal) produced by the board's encoder path. It collects one encoded frame from the UART receiver, runs add-compare-select (ACS) over the whole frame, then traces back. It transmits the decoded bytes to the UART transmitter and reports the corrected path metric. It sits between `async_receiver` and `async_transmitter` in the decode build of the board top.

## Interface
Parameters:
- `FRAME_BYTES`, default 4: decoded bytes per frame, legal range 1..8.
  - Derived: SYMS = 8*FRAME_BYTES symbols per frame; 2*FRAME_BYTES encoded input bytes per frame.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`  in  8  encoded byte from the receiver.
- `flush`  in  1  debounced abort. Returns the block to COLLECT.
- `tx_busy`  in  1  transmitter busy.
- `tx_start`  out  1  one-cycle start strobe to the transmitter.
- `tx_data`  out  8  decoded byte. Held stable from `tx_start` until the next `tx_start`.
- `busy`  out  1  high in every state except COLLECT.
- `frame_done`  out  1  one-cycle pulse when the last decoded byte has finished transmitting.
- `err_count`  out  8  final minimum path metric (Hamming distance) of the last decoded frame.

## Operation
Code convention:
- State s = {s1,s0}, where s1 is the most recent input bit.
- For input u: c0 = u^s1^s0 and c1 = u^s0.
- Next state = {u,s1}. The encoder starts in state 00. There is no tail.

Input packing:
- Input byte j carries symbols 4j..4j+3.
- Symbol k of a byte occupies bits [2k+1:2k], with c0 in bit 2k+1 and c1 in bit 2k.

Output packing:
- Decoded bit t goes to output byte t/8, bit t%8 (LSB first).
- Output bytes are sent in order 0..FRAME_BYTES-1.

FSM states:
- COLLECT
  - Each `rx_valid` stores `rx_data` at the next byte slot.
  - After byte 2*FRAME_BYTES-1 is stored, go to ACS.
  - On entry: path metrics = {0, INF, INF, INF}, where INF = 2*SYMS+1. Metrics are 9 bits wide.
- ACS
  - Processes one symbol per cycle, t = 0..SYMS-1.
  - Branch metric = Hamming distance between the received pair and the expected (c0,c1).
  - For next state {u,a}, the candidates are predecessors {a,0} and {a,1}.
  - Keep the smaller candidate metric. On a tie, choose predecessor {a,0}.
  - Store decision bit = s0 of the chosen predecessor in survivor[t][ns].
  - After t = SYMS-1:
    - Start state = argmin of the metrics (tie → lowest index).
    - `err_count` is loaded with that metric.
    - Go to TRACE.
- TRACE
  - One step per cycle, t = SYMS-1 down to 0.
  - Decoded bit t = state[1].
  - state ← {state[0], survivor[t][state]}.
  - Then go to SEND.
- SEND
  - Wait for `tx_busy`=0.
  - Drive `tx_data` and pulse `tx_start` for 1 cycle, then go to WAIT_HI.
- WAIT_HI
  - Wait for `tx_busy`=1.
- WAIT_LO
  - Wait for `tx_busy`=0.
  - If more bytes remain, go to SEND.
  - Otherwise pulse `frame_done` and go to COLLECT.

Boundary rules:
- `rx_valid` outside COLLECT: the byte is dropped and no state changes.
- `flush` in any state, next cycle:
  - Go to COLLECT with the byte count zeroed.
  - `tx_start`=0 and `frame_done`=0.
  - `err_count` keeps its prior value.
  - A byte already handed to the transmitter completes on its own.
- `flush` and `rx_valid` in the same cycle: `flush` wins and the byte is dropped.
- `rst_n`=0 overrides everything, including mid-frame. State is COLLECT with all counters zeroed.
- Metric arithmetic never overflows: maximum metric is INF + 2*SYMS ≤ 257. No normalisation is needed.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0x00, `busy`=0, `frame_done`=0, `err_count`=0.
  - Metrics, survivors and counters are cleared.
- Last input byte stored at cycle N: ACS occupies N+1..N+SYMS; TRACE occupies the next SYMS cycles.
  - The first `tx_start` is no earlier than N+2*SYMS+1.
- `tx_start` is never asserted while `tx_busy`=1.
- Exactly one `tx_start` per decoded byte.
- `err_count` updates on the last ACS cycle and is stable until the next frame's last ACS cycle.
- `busy` rises the cycle after the final input byte is stored. It falls in the same cycle as the `frame_done` pulse.

## Test plan
- Default parameters; input bytes A7 AA AA AA AA AA AA AA (all-ones data) → `tx_data` FF FF FF FF, 4 `tx_start` pulses, `err_count`=0, one `frame_done`.
- Same frame with byte 3 changed to 0xAB (single channel bit flip) → FF FF FF FF, `err_count`=1. Eight bytes 0x00 → 00 00 00 00, `err_count`=0.
- Data EF BE AD DE encoded by the reference model, with two flips ≥ 10 symbols apart → EF BE AD DE, `err_count`=2.
- Transmitter model holds `tx_busy` high for 50 cycles per byte → no `tx_start` while busy, exactly 4 pulses in order, `tx_data` stable between pulses.
- 3 bytes received, then `flush`; then a full all-zero frame → no output for the partial frame, then 00 00 00 00.
- `rx_valid` strobes during ACS/TRACE are ignored, and the frame still decodes correctly. `rst_n` low mid-SEND → no further `tx_start`, outputs at reset values, next frame decodes correctly.

Source files
------------

// File: rtl/viterbi_frame_decoder.sv
// viterbi_frame_decoder: hard-decision Viterbi decoder for the rate-1/2 K=3 (7,5) code.
// Buffers one encoded frame, runs ACS over it, traces back and streams the decoded bytes out.
module viterbi_frame_decoder #(
  parameter int FRAME_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       flush,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] err_count
);
  localparam int SYMS = 8 * FRAME_BYTES;
  localparam int IN_BYTES = 2 * FRAME_BYTES;
  localparam int TW = $clog2(SYMS);
  localparam int BW = $clog2(IN_BYTES);
  localparam int OW = FRAME_BYTES > 1 ? $clog2(FRAME_BYTES) : 1;
  localparam logic [8:0] INF = 9'(2 * SYMS + 1);

  typedef enum logic [2:0] {S_COLLECT, S_ACS, S_TRACE, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;

  state_t          r_st;
  logic [7:0]      r_rx [IN_BYTES];
  logic [BW-1:0]   r_cnt;
  logic [TW-1:0]   r_t;
  logic [OW-1:0]   r_ob;
  logic [8:0]      r_pm [4];
  logic [3:0]      r_surv [SYMS];
  logic [1:0]      r_state;
  logic [SYMS-1:0] r_dec;
  logic [7:0]      w_byte;
  logic [1:0]      w_sym;
  logic [8:0]      w_npm [4];
  logic [3:0]      w_dec;
  logic [1:0]      w_best;
  logic [8:0]      w_min;

  function automatic logic [1:0] f_bm(input logic [1:0] s, input logic u, input logic [1:0] rx);
    logic [1:0] x;
    x = {u ^ s[1] ^ s[0], u ^ s[0]} ^ rx;
    return 2'(x[1]) + 2'(x[0]);
  endfunction

  // Four symbols per input byte; c0 sits in the upper bit of each pair.
  assign w_byte = r_rx[r_t[TW-1:2]];
  assign w_sym  = 2'(w_byte >> {r_t[1:0], 1'b0});

  for (genvar n = 0; n < 4; n++) begin : g_acs
    localparam logic [1:0] P0 = 2'(2 * (n % 2));
    localparam logic [1:0] P1 = 2'(2 * (n % 2) + 1);
    localparam logic U = n >= 2;
    logic [8:0] w_m0, w_m1;
    assign w_m0     = r_pm[P0] + 9'(f_bm(P0, U, w_sym));
    assign w_m1     = r_pm[P1] + 9'(f_bm(P1, U, w_sym));
    assign w_dec[n] = w_m1 < w_m0;
    assign w_npm[n] = w_dec[n] ? w_m1 : w_m0;
  end

  always_comb begin
    w_best = 2'd0;
    w_min  = w_npm[0];
    for (int i = 1; i < 4; i++) begin
      w_best = w_npm[i] < w_min ? 2'(i) : w_best;
      w_min  = w_npm[i] < w_min ? w_npm[i] : w_min;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st       <= S_COLLECT;
      r_rx       <= '{default: '0};
      r_cnt      <= '0;
      r_t        <= '0;
      r_ob       <= '0;
      r_pm       <= '{default: '0};
      r_surv     <= '{default: '0};
      r_state    <= '0;
      r_dec      <= '0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= 8'h00;
    end else if (flush) begin
      r_st       <= S_COLLECT;
      r_cnt      <= '0;
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      frame_done <= 1'b0;
      case (r_st)
        S_COLLECT: if (rx_valid) begin
          r_rx[r_cnt] <= rx_data;
          r_cnt       <= r_cnt + 1'b1;
          if (r_cnt == BW'(IN_BYTES - 1)) begin
            r_cnt <= '0;
            r_t   <= '0;
            r_pm  <= '{9'd0, INF, INF, INF};
            busy  <= 1'b1;
            r_st  <= S_ACS;
          end
        end
        S_ACS: begin
          r_pm        <= w_npm;
          r_surv[r_t] <= w_dec;
          r_t         <= r_t + 1'b1;
          if (r_t == TW'(SYMS - 1)) begin
            r_t       <= TW'(SYMS - 1);
            r_state   <= w_best;
            err_count <= 8'(w_min);
            r_st      <= S_TRACE;
          end
        end
        S_TRACE: begin
          r_dec[r_t] <= r_state[1];
          r_state    <= {r_state[0], r_surv[r_t][r_state]};
          r_t        <= r_t - 1'b1;
          if (r_t == '0) begin
            r_ob <= '0;
            r_st <= S_SEND;
          end
        end
        S_SEND: if (!tx_busy) begin
          tx_data  <= r_dec[8*r_ob +: 8];
          tx_start <= 1'b1;
          r_st     <= S_WAIT_HI;
        end
        S_WAIT_HI: if (tx_busy) r_st <= S_WAIT_LO;
        S_WAIT_LO: if (!tx_busy) begin
          if (r_ob == OW'(FRAME_BYTES - 1)) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            r_st       <= S_COLLECT;
          end else begin
            r_ob <= r_ob + 1'b1;
            r_st <= S_SEND;
          end
        end
        default: r_st <= S_COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_viterbi_frame_decoder.sv
// tb_viterbi_frame_decoder: randomized self-checking bench for viterbi_frame_decoder.
// Reference is a register-exchange Viterbi model plus a simple encoder, pinned by hand vectors.
module tb_viterbi_frame_decoder;
  localparam int FB = 4;
  localparam int SYMS = 8 * FB;
  localparam int IN_BYTES = 2 * FB;
  localparam int INF = 2 * SYMS + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_start, busy, frame_done, tx_busy;
  logic [7:0] tx_data, err_count;

  int n_checks = 0, n_pass = 0, cyc = 0, t_last = 0, got = 0, stab_err = 0;
  int done_cnt = 0, prev_err = 0, exp_err = 0, tx_cnt = 0, busy_len = 4, m_err = 0;
  bit expecting = 1'b0;
  logic [7:0] held = 8'h00;
  logic [7:0] enc [IN_BYTES];
  logic [7:0] exp_bytes [FB];
  logic [7:0] m_bytes [FB];

  viterbi_frame_decoder #(.FRAME_BYTES(FB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .flush(flush),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
    .frame_done(frame_done), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: goes busy the cycle after a start strobe and stays busy for busy_len cycles.
  assign tx_busy = tx_cnt != 0;
  always @(posedge clk) tx_cnt <= tx_cnt != 0 ? tx_cnt - 1 : (tx_start ? busy_len : 0);

  task automatic check(input bit ok, input string name, input int act, input int want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, want, want);
  endtask

  always @(negedge clk) begin
    if (!rst_n) held = tx_data;
    else begin
      if (tx_start) begin
        check(!tx_busy, "tx_start_while_tx_busy", int'(tx_busy), 0);
        if (got == 0)
          check(cyc - t_last >= 2 * SYMS + 1, "first_tx_start_latency", cyc - t_last, 2 * SYMS + 1);
        if (expecting && got < FB)
          check(tx_data == exp_bytes[got], $sformatf("tx_data[%0d]", got), int'(tx_data), int'(exp_bytes[got]));
        else check(1'b0, "unexpected_tx_start", got, FB);
        got++;
        held = tx_data;
      end else if (tx_data != held) stab_err++;
      if (frame_done) begin
        check(expecting && got == FB, "tx_start_count", got, FB);
        check(int'(err_count) == exp_err, "err_count_at_done", int'(err_count), exp_err);
        check(!busy, "busy_low_at_done", int'(busy), 0);
        check(stab_err == 0, "tx_data_stable", stab_err, 0);
        done_cnt++;
        expecting = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic encode(input logic [SYMS-1:0] d);
    logic s1, s0, u;
    s1 = 1'b0;
    s0 = 1'b0;
    for (int j = 0; j < IN_BYTES; j++) enc[j] = 8'h00;
    for (int t = 0; t < SYMS; t++) begin
      u = d[t];
      enc[t/4][2*(t%4)+1] = u ^ s1 ^ s0;
      enc[t/4][2*(t%4)]   = u ^ s0;
      s0 = s1;
      s1 = u;
    end
  endtask

  // Register-exchange decoder: each state carries its whole surviving bit history.
  task automatic model_decode;
    int pm [4];
    int npm [4];
    int bp, best, m, u, p;
    logic [SYMS-1:0] path [4];
    logic [SYMS-1:0] npath [4];
    logic [1:0] r;
    pm = '{0, INF, INF, INF};
    for (int s = 0; s < 4; s++) path[s] = '0;
    for (int t = 0; t < SYMS; t++) begin
      r = 2'(enc[t/4] >> (2 * (t % 4)));
      for (int ns = 0; ns < 4; ns++) begin
        u = ns / 2;
        best = -1;
        bp = 0;
        for (int k = 0; k < 2; k++) begin
          p = 2 * (ns % 2) + k;
          m = pm[p] + int'((u ^ p / 2 ^ p % 2) != int'(r[1])) + int'((u ^ p % 2) != int'(r[0]));
          if (best < 0 || m < best) begin
            best = m;
            bp = p;
          end
        end
        npm[ns] = best;
        npath[ns] = path[bp];
        npath[ns][t] = u[0];
      end
      pm = npm;
      path = npath;
    end
    bp = 0;
    for (int s = 1; s < 4; s++) if (pm[s] < pm[bp]) bp = s;
    m_err = pm[bp];
    for (int i = 0; i < FB; i++) m_bytes[i] = path[bp][8*i +: 8];
  endtask

  function automatic int mword();
    return int'({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
  endfunction

  task automatic check_reset_vals;
    check(!tx_start, "reset_tx_start", int'(tx_start), 0);
    check(tx_data == 8'h00, "reset_tx_data", int'(tx_data), 0);
    check(!busy, "reset_busy", int'(busy), 0);
    check(!frame_done, "reset_frame_done", int'(frame_done), 0);
    check(err_count == 8'h00, "reset_err_count", int'(err_count), 0);
  endtask

  task automatic start_frame(input bit junk, input int blen);
    model_decode;
    for (int i = 0; i < FB; i++) exp_bytes[i] = m_bytes[i];
    exp_err = m_err;
    busy_len = blen;
    got = 0;
    stab_err = 0;
    expecting = 1'b1;
    for (int j = 0; j < IN_BYTES; j++) begin
      rx_data = enc[j];
      rx_valid = 1'b1;
      if (j == IN_BYTES - 1) check(!busy, "busy_low_before_last_byte", int'(busy), 0);
      tick;
      rx_valid = 1'b0;
      if (j < IN_BYTES - 1) repeat ($urandom_range(0, 2)) tick;
    end
    t_last = cyc;
    check(busy, "busy_rise_after_last_byte", int'(busy), 1);
    for (int c = 1; c < 2 * SYMS; c++) begin
      rx_valid = junk && ($urandom_range(0, 1) == 1);
      rx_data = 8'($urandom);
      tick;
      if (c == SYMS - 1) check(int'(err_count) == prev_err, "err_count_hold", int'(err_count), prev_err);
      if (c == SYMS) check(int'(err_count) == exp_err, "err_count_load", int'(err_count), exp_err);
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done;
    int d0, k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 4000) begin
      tick;
      k++;
    end
    check(done_cnt != d0, "frame_done_seen", k, 4000);
    prev_err = exp_err;
  endtask

  task automatic run_frame(input bit junk, input int blen);
    start_frame(junk, blen);
    wait_done;
  endtask

  initial begin
    int k;
    repeat (3) tick;
    check_reset_vals;
    rst_n = 1'b1;
    tick;

    // All-ones data: encoder and decoder pinned by hand.
    encode({SYMS{1'b1}});
    for (int j = 0; j < IN_BYTES; j++)
      check(enc[j] == (j == 0 ? 8'hA7 : 8'hAA), $sformatf("encode_ones[%0d]", j), int'(enc[j]), j == 0 ? 'hA7 : 'hAA);
    model_decode;
    check(mword() == 32'hFFFFFFFF, "model_ones_bytes", mword(), 32'hFFFFFFFF);
    check(m_err == 0, "model_ones_err", m_err, 0);
    run_frame(1'b0, 3);

    // Single channel bit flip.
    enc[3] = 8'hAB;
    model_decode;
    check(mword() == 32'hFFFFFFFF, "model_flip1_bytes", mword(), 32'hFFFFFFFF);
    check(m_err == 1, "model_flip1_err", m_err, 1);
    run_frame(1'b0, 5);

    // All-zero frame.
    for (int j = 0; j < IN_BYTES; j++) enc[j] = 8'h00;
    model_decode;
    check(mword() == 0, "model_zero_bytes", mword(), 0);
    check(m_err == 0, "model_zero_err", m_err, 0);
    run_frame(1'b0, 1);

    // DEADBEEF with two separated flips (symbols 5 and 18), slow transmitter.
    encode(32'hDEADBEEF);
    enc[1][3] = ~enc[1][3];
    enc[4][4] = ~enc[4][4];
    model_decode;
    check(mword() == 32'hDEADBEEF, "model_2flip_bytes", mword(), 32'hDEADBEEF);
    check(m_err == 2, "model_2flip_err", m_err, 2);
    run_frame(1'b0, 50);

    // Partial frame then flush (with a colliding rx_valid), then a clean zero frame.
    expecting = 1'b0;
    for (int j = 0; j < 3; j++) begin
      rx_data = 8'h00;
      rx_valid = 1'b1;
      tick;
      rx_valid = 1'b0;
    end
    flush = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h55;
    tick;
    flush = 1'b0;
    rx_valid = 1'b0;
    check(!busy, "busy_after_flush", int'(busy), 0);
    check(int'(err_count) == prev_err, "err_count_kept_after_flush", int'(err_count), prev_err);
    repeat (20) tick;
    for (int j = 0; j < IN_BYTES; j++) enc[j] = 8'h00;
    run_frame(1'b0, 2);

    // Junk rx_valid strobes during ACS and TRACE.
    encode(SYMS'($urandom));
    run_frame(1'b1, 4);

    // Reset in the middle of transmitting.
    encode(SYMS'($urandom));
    start_frame(1'b0, 50);
    k = 0;
    while (got < 1 && k < 2000) begin
      tick;
      k++;
    end
    check(got >= 1, "first_tx_before_reset", got, 1);
    rst_n = 1'b0;
    expecting = 1'b0;
    tick;
    tick;
    check_reset_vals;
    rst_n = 1'b1;
    prev_err = 0;
    repeat (100) tick;
    encode(SYMS'($urandom));
    run_frame(1'b0, 3);

    // Randomized frames with random channel flips.
    for (int f = 0; f < 8; f++) begin
      encode(SYMS'($urandom));
      repeat ($urandom_range(0, 3)) begin
        k = $urandom_range(0, IN_BYTES - 1);
        enc[k] = enc[k] ^ (8'h01 << $urandom_range(0, 7));
      end
      run_frame(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
